// File: rtl/dpa_allocator.sv
// dpa_allocator -- diagonal propagation wavefront allocator (N inputs x N outputs).
//
// Diagonals are scanned starting at the rotating priority pointer; each
// requested cell is granted unless an earlier diagonal already claimed its
// row or column. This yields at most one grant per row and per column.
// The grant matrix is registered, giving a latency of one cycle.
//
// Optional feature macro: DPA_LOCK_EN
//   When defined, adds a per-input hold port and lock registers. A granted
//   pair (i,j) with hold[i]=1 becomes locked and is re-granted every cycle
//   while hold[i] and request[i][j] stay high. A locked row and column are
//   kept out of the wavefront until the cycle after the lock is released.
//
// Ports:
//   clk         - sole clock, rising edge
//   rst         - synchronous active-high reset
//   en          - allocation enable
//   request     - request[i][j]=1 : input i requests output j
//   hold        - per-input lock request (DPA_LOCK_EN only)
//   grant       - registered grant matrix, same indexing as request
//   grant_valid - registered, 1 when any grant bit is set
//   prio        - current priority diagonal pointer
module dpa_allocator #(
   parameter  int N  = 4,
   localparam int PW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [N-1:0][N-1:0]   request,
`ifdef DPA_LOCK_EN
   input  logic [N-1:0]          hold,
`endif
   output logic [N-1:0][N-1:0]   grant,
   output logic                  grant_valid,
   output logic [PW-1:0]         prio
);

   logic [PW-1:0]         prio_r;
   logic [PW-1:0]         prio_next_s;
   logic [N-1:0][N-1:0]   wave_grant_s;   // grants issued by the wavefront
   logic [N-1:0][N-1:0]   lock_grant_s;   // grants re-issued to locked pairs
   logic [N-1:0][N-1:0]   grant_next_s;
   logic                  wave_any_s;
   logic [N-1:0]          row_busy_s;
   logic [N-1:0]          col_busy_s;

`ifdef DPA_LOCK_EN
   logic [N-1:0]          lock_vld_r;
   logic [N-1:0][PW-1:0]  lock_out_r;

   // Index of the set bit in a one-hot row (rows carry at most one grant).
   function automatic logic [PW-1:0] onehot_idx(input logic [N-1:0] v);
      logic [PW-1:0] idx;
      idx = '0;
      for (int b = 0; b < N; b++) begin
         if (v[b]) begin
            idx = PW'(b);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction
`endif

   // Wavefront evaluation: locked pairs claim their row/column first, then diagonals from prio.
   always_comb begin
      int j_v;
      row_busy_s   = '0;
      col_busy_s   = '0;
      wave_grant_s = '0;
      lock_grant_s = '0;
      j_v          = 0;
`ifdef DPA_LOCK_EN
      for (int i = 0; i < N; i++) begin
         if (lock_vld_r[i]) begin
            // The row/column stay reserved even in the release cycle.
            row_busy_s[i]             = 1'b1;
            col_busy_s[lock_out_r[i]] = 1'b1;
            if (hold[i] && request[i][lock_out_r[i]]) begin
               lock_grant_s[i][lock_out_r[i]] = 1'b1;
            end else begin
               lock_grant_s[i][lock_out_r[i]] = 1'b0;
            end
         end else begin
            row_busy_s[i] = row_busy_s[i];
         end
      end
`endif
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            j_v = (i + int'(prio_r) + k) % N;
            if (request[i][j_v] && !row_busy_s[i] && !col_busy_s[j_v]) begin
               wave_grant_s[i][j_v] = 1'b1;
               row_busy_s[i]        = 1'b1;
               col_busy_s[j_v]      = 1'b1;
            end else begin
               wave_grant_s[i][j_v] = wave_grant_s[i][j_v];
            end
         end
      end
   end

   assign grant_next_s = wave_grant_s | lock_grant_s;
   assign wave_any_s   = |wave_grant_s;
   assign prio_next_s  = (prio_r == PW'(N - 1)) ? '0 : prio_r + 1'b1;
   assign prio         = prio_r;

   // Grant/priority registers; prio only moves on a non-locked grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant       <= '0;
         grant_valid <= 1'b0;
         prio_r      <= '0;
      end else if (en) begin
         grant       <= grant_next_s;
         grant_valid <= |grant_next_s;
         if (wave_any_s) begin
            prio_r <= prio_next_s;
         end else begin
            prio_r <= prio_r;
         end
      end else begin
         grant       <= '0;
         grant_valid <= 1'b0;
         prio_r      <= prio_r;
      end
   end

`ifdef DPA_LOCK_EN
   // Lock registers: set on a held wavefront grant, cleared when hold or request drops.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            lock_vld_r[i] <= 1'b0;
            lock_out_r[i] <= '0;
         end else if (en) begin
            if (lock_vld_r[i]) begin
               if (!(hold[i] && request[i][lock_out_r[i]])) begin
                  lock_vld_r[i] <= 1'b0;
               end else begin
                  lock_vld_r[i] <= 1'b1;
               end
            end else if (hold[i] && (|wave_grant_s[i])) begin
               lock_vld_r[i] <= 1'b1;
               lock_out_r[i] <= onehot_idx(wave_grant_s[i]);
            end else begin
               lock_vld_r[i] <= lock_vld_r[i];
            end
         end else begin
            // Locks are retained while allocation is disabled.
            lock_vld_r[i] <= lock_vld_r[i];
         end
      end
   end
`endif

endmodule

// File: tb/tb_dpa_allocator.sv
module tb_dpa_allocator;

   localparam int N = 4;
`ifdef DPA_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic                clk;
   logic                rst;
   logic                en;
   logic [N-1:0][N-1:0] request;
   logic [N-1:0]        hold;
   logic [N-1:0][N-1:0] grant;
   logic                grant_valid;
   logic [1:0]          prio;

   dpa_allocator #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .request     (request),
`ifdef DPA_LOCK_EN
      .hold        (hold),
`endif
      .grant       (grant),
      .grant_valid (grant_valid),
      .prio        (prio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0][N-1:0] g;
      logic                gv;
      logic [1:0]          p;
   } exp_t;

   exp_t sb_q[$];
   int   checks_cnt = 0;
   int   fail_cnt   = 0;

   // Reference model state
   int       m_prio = 0;
   bit [N-1:0] m_lock_vld = '0;
   int       m_lock_out[N];

   logic [N-1:0][N-1:0] last_grant;
   logic [1:0]          last_prio;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compute the expected outcome of the coming edge and advance the model.
   task automatic model_push(input logic r, input logic e,
                             input logic [N-1:0][N-1:0] rq, input logic [N-1:0] hd);
      exp_t                x;
      logic [N-1:0]        rb;
      logic [N-1:0]        cb;
      logic [N-1:0][N-1:0] g;
      logic [N-1:0][N-1:0] w;
      rb = '0; cb = '0; g = '0; w = '0;
      if (r) begin
         m_prio     = 0;
         m_lock_vld = '0;
         x.g = '0; x.gv = 1'b0; x.p = 2'd0;
         sb_q.push_back(x);
         return;
      end
      for (int i = 0; i < N; i++) begin
         if (LOCK_EN && m_lock_vld[i]) begin
            rb[i] = 1'b1;
            cb[m_lock_out[i]] = 1'b1;
            if (hd[i] && rq[i][m_lock_out[i]]) g[i][m_lock_out[i]] = 1'b1;
         end
      end
      for (int d = 0; d < N; d++) begin
         for (int i = 0; i < N; i++) begin
            int j;
            j = (i + ((m_prio + d) % N)) % N;
            if (rq[i][j] && !rb[i] && !cb[j]) begin
               w[i][j] = 1'b1; rb[i] = 1'b1; cb[j] = 1'b1;
            end
         end
      end
      if (e) begin
         x.g  = g | w;
         x.gv = |(g | w);
         for (int i = 0; i < N; i++) begin
            if (m_lock_vld[i]) begin
               if (!(hd[i] && rq[i][m_lock_out[i]])) m_lock_vld[i] = 1'b0;
            end else if (LOCK_EN && hd[i]) begin
               for (int j = 0; j < N; j++) begin
                  if (w[i][j]) begin
                     m_lock_vld[i] = 1'b1;
                     m_lock_out[i] = j;
                  end
               end
            end
         end
         if (|w) m_prio = (m_prio + 1) % N;
      end else begin
         x.g = '0; x.gv = 1'b0;
      end
      x.p = 2'(m_prio);
      sb_q.push_back(x);
   endtask

   // Drive one cycle of stimulus, then compare the DUT against the scoreboard.
   task automatic step(input string tag, input logic r, input logic e,
                       input logic [N-1:0][N-1:0] rq, input logic [N-1:0] hd);
      exp_t x;
      logic excl_ok;
      rst = r; en = e; request = rq; hold = hd;
      model_push(r, e, rq, hd);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         x = sb_q.pop_front();
         check_eq({tag, "_grant"}, 64'(grant), 64'(x.g));
         check_eq({tag, "_gvalid"}, 64'(grant_valid), 64'(x.gv));
         check_eq({tag, "_prio"}, 64'(prio), 64'(x.p));
      end
      excl_ok = 1'b1;
      for (int i = 0; i < N; i++) begin
         int rc;
         int cc;
         rc = 0; cc = 0;
         for (int j = 0; j < N; j++) begin
            rc += int'(grant[i][j]);
            cc += int'(grant[j][i]);
         end
         if (rc > 1 || cc > 1) excl_ok = 1'b0;
      end
      check_eq({tag, "_excl"}, 64'(excl_ok), 64'd1);
      last_grant = grant;
      last_prio  = prio;
   endtask

   initial begin
      logic [N-1:0][N-1:0] rq_v;
      logic [1:0]          frozen_v;
      logic [63:0]         col0_exp[5];
      rst = 1'b1; en = 1'b0; request = '0; hold = '0;
      for (int i = 0; i < N; i++) m_lock_out[i] = 0;

      // Reset held two cycles with all requests asserted
      step("rst0", 1'b1, 1'b1, 16'hFFFF, 4'h0);
      check_eq("rst0_zero", 64'(grant), 64'd0);
      step("rst1", 1'b1, 1'b1, 16'hFFFF, 4'h0);
      check_eq("rst1_prio", 64'(prio), 64'd0);
      step("rel", 1'b0, 1'b1, 16'hFFFF, 4'h0);
      check_eq("rel_diag0", 64'(last_grant), 64'h8421);

      // Off-diagonal requests from prio=0
      step("rst2", 1'b1, 1'b0, 16'h0000, 4'h0);
      step("off0", 1'b0, 1'b1, 16'h7BDE, 4'h0);
      check_eq("off0_c", 64'(last_grant), 64'h1842);
      check_eq("off0_p", 64'(last_prio), 64'd1);
      step("off1", 1'b0, 1'b1, 16'h7BDE, 4'h0);
      check_eq("off1_c", 64'(last_grant), 64'h1842);
      check_eq("off1_p", 64'(last_prio), 64'd2);
      step("off2", 1'b0, 1'b1, 16'h7BDE, 4'h0);
      check_eq("off2_c", 64'(last_grant), 64'h2184);
      check_eq("off2_p", 64'(last_prio), 64'd3);

      // Everyone asks for output 0: winner rotates 0,3,2,1,0
      col0_exp[0] = 64'h0001; col0_exp[1] = 64'h1000; col0_exp[2] = 64'h0100;
      col0_exp[3] = 64'h0010; col0_exp[4] = 64'h0001;
      step("rst3", 1'b1, 1'b0, 16'h0000, 4'h0);
      for (int c = 0; c < 5; c++) begin
         step("col0", 1'b0, 1'b1, 16'h1111, 4'h0);
         check_eq("col0_c", 64'(last_grant), col0_exp[c]);
         check_eq("col0_one", 64'($countones(last_grant)), 64'd1);
      end

      // Enable gap during full requests
      step("full", 1'b0, 1'b1, 16'hFFFF, 4'h0);
      frozen_v = last_prio;
      for (int c = 0; c < 3; c++) begin
         step("en0", 1'b0, 1'b0, 16'hFFFF, 4'h0);
         check_eq("en0_prio", 64'(last_prio), 64'(frozen_v));
      end
      step("en1", 1'b0, 1'b1, 16'hFFFF, 4'h0);
      step("zero", 1'b0, 1'b1, 16'h0000, 4'h0);
      check_eq("zero_gv", 64'(grant_valid), 64'd0);

      // Random traffic with occasional reset and enable drops
      for (int c = 0; c < 60; c++) begin
         rq_v = 16'($urandom());
         step("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
              rq_v, 4'($urandom()));
      end

`ifdef DPA_LOCK_EN
      // Input 1 locks output 2, then holds it against competitors
      step("lrst", 1'b1, 1'b0, 16'h0000, 4'h0);
      step("lset", 1'b0, 1'b1, 16'h0040, 4'h2);
      for (int c = 0; c < 4; c++) begin
         step("lhold", 1'b0, 1'b1, 16'h4444, 4'h2);
         check_eq("lhold_c", 64'(last_grant), 64'h0040);
      end
      step("lrel", 1'b0, 1'b1, 16'h4444, 4'h0);
      step("lnext", 1'b0, 1'b1, 16'h4444, 4'h0);
      // Reset in the middle of a lock
      step("lset2", 1'b0, 1'b1, 16'h0040, 4'h2);
      step("lhold2", 1'b0, 1'b1, 16'h4444, 4'h2);
      step("lmrst", 1'b1, 1'b1, 16'h4444, 4'h2);
      step("lpost", 1'b0, 1'b1, 16'h4444, 4'h0);
      check_eq("lpost_c", 64'(last_grant), 64'h0400);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
